// File: rtl/acc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : acc_unit_if
//  Description : Bus bundle for the accumulator unit: load sources, in-place
//                op select, data-memory store handshake and result outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface acc_unit_if #(
    parameter int DW = 32,
    parameter int MW = 8,
    parameter int CW = 20,
    parameter int LW = 9
);
    logic [DW-1:0] cbus_data;
    logic          cbus_ld;
    logic [MW-1:0] dm_data;
    logic          dm_ld;
    logic [CW-1:0] cm_data;
    logic          cm_ld;
    logic          ext_signed;
    logic [2:0]    op;
    logic          st_req;
    logic          st_ready;
    logic          st_valid;
    logic [MW-1:0] st_data;
    logic          st_ovf;
    logic [DW-1:0] abus_out;
    logic [LW-1:0] acc_low;
    logic          flag_z;
    logic          flag_n;
    logic          flag_c;

    // Side that drives loads/ops and accepts stores.
    modport master (
        output cbus_data, cbus_ld, dm_data, dm_ld, cm_data, cm_ld,
               ext_signed, op, st_req, st_ready,
        input  st_valid, st_data, st_ovf, abus_out, acc_low,
               flag_z, flag_n, flag_c
    );

    // The accumulator unit itself.
    modport slave (
        input  cbus_data, cbus_ld, dm_data, dm_ld, cm_data, cm_ld,
               ext_signed, op, st_req, st_ready,
        output st_valid, st_data, st_ovf, abus_out, acc_low,
               flag_z, flag_n, flag_c
    );
endinterface
`default_nettype wire

// File: rtl/acc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : acc_unit
//  Description : Accumulator with prioritised loads (code mem > data mem >
//                C-bus > in-place op), carry flag, and a one-deep store
//                buffer towards data memory with sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_unit #(
    parameter int DW = 32,
    parameter int MW = 8,
    parameter int CW = 20,
    parameter int LW = 9
) (
    input  wire logic clk,
    input  wire logic rst,
    acc_unit_if.slave bus
);
    localparam logic [2:0] c_OP_INC = 3'd1;
    localparam logic [2:0] c_OP_DEC = 3'd2;
    localparam logic [2:0] c_OP_SHL = 3'd3;
    localparam logic [2:0] c_OP_SHR = 3'd4;
    localparam logic [2:0] c_OP_CLR = 3'd5;

    logic [DW-1:0] r_acc;
    logic          r_flag_c;
    logic          r_st_valid;
    logic [MW-1:0] r_st_data;
    logic          r_st_ovf;

    logic [DW-1:0] w_cm_ext;
    logic [DW-1:0] w_dm_ext;
    logic [DW-1:0] w_acc_nxt;
    logic          w_c_nxt;
    logic          w_st_take;
    logic          w_st_drain;
    logic          w_st_drop;

    // Widen the memory load values; bits above the source width take the
    // source MSB when sign extension is selected, zero otherwise.
    always_comb begin
        w_cm_ext = '0;
        w_dm_ext = '0;
        for (int i = 0; i < DW; i++) begin
            if (i < CW) w_cm_ext[i] = bus.cm_data[i];
            else        w_cm_ext[i] = bus.ext_signed & bus.cm_data[CW-1];
            if (i < MW) w_dm_ext[i] = bus.dm_data[i];
            else        w_dm_ext[i] = bus.ext_signed & bus.dm_data[MW-1];
        end
    end

    // Next accumulator value and carry: one source wins per cycle.
    always_comb begin
        w_acc_nxt = r_acc;
        w_c_nxt   = r_flag_c;
        if (bus.cm_ld) begin
            w_acc_nxt = w_cm_ext;
            w_c_nxt   = 1'b0;
        end else if (bus.dm_ld) begin
            w_acc_nxt = w_dm_ext;
            w_c_nxt   = 1'b0;
        end else if (bus.cbus_ld) begin
            w_acc_nxt = bus.cbus_data;
            w_c_nxt   = 1'b0;
        end else begin
            case (bus.op)
                c_OP_INC: begin
                    w_acc_nxt = r_acc + 1'b1;
                    w_c_nxt   = &r_acc;
                end
                c_OP_DEC: begin
                    w_acc_nxt = r_acc - 1'b1;
                    w_c_nxt   = ~|r_acc;
                end
                c_OP_SHL: begin
                    w_acc_nxt = {r_acc[DW-2:0], 1'b0};
                    w_c_nxt   = r_acc[DW-1];
                end
                c_OP_SHR: begin
                    w_acc_nxt = {1'b0, r_acc[DW-1:1]};
                    w_c_nxt   = r_acc[0];
                end
                c_OP_CLR: begin
                    w_acc_nxt = '0;
                    w_c_nxt   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Accumulator and carry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_flag_c <= 1'b0;
        end else begin
            r_acc    <= w_acc_nxt;
            r_flag_c <= w_c_nxt;
        end
    end

    // Store buffer decisions: accept into an empty (or simultaneously
    // draining) slot, drain on ready, flag a request that finds it full.
    always_comb begin
        w_st_take  = bus.st_req & (~r_st_valid | bus.st_ready);
        w_st_drain = r_st_valid & bus.st_ready;
        w_st_drop  = bus.st_req & r_st_valid & ~bus.st_ready;
    end

    // Store buffer registers; the captured word is the pre-update acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st_valid <= 1'b0;
            r_st_data  <= '0;
            r_st_ovf   <= 1'b0;
        end else begin
            if (w_st_take) begin
                r_st_valid <= 1'b1;
                r_st_data  <= r_acc[MW-1:0];
            end else if (w_st_drain) begin
                r_st_valid <= 1'b0;
            end
            if (w_st_drop) r_st_ovf <= 1'b1;
        end
    end

    assign bus.abus_out = r_acc;
    assign bus.acc_low  = r_acc[LW-1:0];
    assign bus.flag_z   = (r_acc == '0);
    assign bus.flag_n   = r_acc[DW-1];
    assign bus.flag_c   = r_flag_c;
    assign bus.st_valid = r_st_valid;
    assign bus.st_data  = r_st_data;
    assign bus.st_ovf   = r_st_ovf;
endmodule
`default_nettype wire

// File: tb/tb_acc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_unit
//  Description : Self-checking bench for acc_unit (DW=32, MW=8, CW=20, LW=9)
//                with a reference model feeding expected-state and
//                expected-store scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_unit;
    logic clk;
    logic rst;

    acc_unit_if #(.DW(32), .MW(8), .CW(20), .LW(9)) u_if ();

    acc_unit #(.DW(32), .MW(8), .CW(20), .LW(9)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    typedef struct {
        logic [31:0] acc;
        logic        c;
        logic        sv;
        logic [7:0]  sd;
        logic        ovf;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] st_q[$];

    logic [31:0] m_acc;
    logic        m_c;
    logic        m_sv;
    logic [7:0]  m_sd;
    logic        m_ovf;

    int n_tests;
    int n_fail;

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Set all inputs for the next cycle (called just after a falling edge).
    task automatic drive(input bit r, input bit cm, input bit dm, input bit cb,
                         input bit es, input logic [2:0] op,
                         input logic [19:0] cmd, input logic [7:0] dmd,
                         input logic [31:0] cbd, input bit req, input bit rdy);
        rst              = r;
        u_if.cm_ld       = cm;
        u_if.dm_ld       = dm;
        u_if.cbus_ld     = cb;
        u_if.ext_signed  = es;
        u_if.op          = op;
        u_if.cm_data     = cmd;
        u_if.dm_data     = dmd;
        u_if.cbus_data   = cbd;
        u_if.st_req      = req;
        u_if.st_ready    = rdy;
    endtask

    // Advance one cycle: model predicts, pushes expectations, clock, compare.
    task automatic tick(input string tag);
        exp_t        e;
        exp_t        g;
        logic [7:0]  w;
        e.acc = m_acc; e.c = m_c; e.sv = m_sv; e.sd = m_sd; e.ovf = m_ovf;
        if (rst) begin
            e.acc = 0; e.c = 0; e.sv = 0; e.sd = 0; e.ovf = 0;
            st_q.delete();
        end else begin
            if (u_if.cm_ld) begin
                e.acc = u_if.ext_signed ? {{12{u_if.cm_data[19]}}, u_if.cm_data}
                                        : {12'h0, u_if.cm_data};
                e.c = 0;
            end else if (u_if.dm_ld) begin
                e.acc = u_if.ext_signed ? {{24{u_if.dm_data[7]}}, u_if.dm_data}
                                        : {24'h0, u_if.dm_data};
                e.c = 0;
            end else if (u_if.cbus_ld) begin
                e.acc = u_if.cbus_data;
                e.c = 0;
            end else begin
                case (u_if.op)
                    3'd1: begin e.acc = m_acc + 32'd1; e.c = (m_acc == 32'hFFFF_FFFF); end
                    3'd2: begin e.acc = m_acc - 32'd1; e.c = (m_acc == 32'h0); end
                    3'd3: begin e.acc = m_acc << 1;    e.c = m_acc[31]; end
                    3'd4: begin e.acc = m_acc >> 1;    e.c = m_acc[0]; end
                    3'd5: begin e.acc = 32'h0;         e.c = 0; end
                    default: ;
                endcase
            end
            if (m_sv && u_if.st_ready) begin
                if (st_q.size() == 0) begin
                    chk({tag, ".st_q_empty"}, 1, 0);
                end else begin
                    w = st_q.pop_front();
                    chk({tag, ".drain_word"}, u_if.st_data, w);
                end
            end
            if (u_if.st_req && (!m_sv || u_if.st_ready)) begin
                st_q.push_back(m_acc[7:0]);
                e.sv = 1;
                e.sd = m_acc[7:0];
            end else if (m_sv && u_if.st_ready) begin
                e.sv = 0;
            end
            if (u_if.st_req && m_sv && !u_if.st_ready) e.ovf = 1;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        m_acc = g.acc; m_c = g.c; m_sv = g.sv; m_sd = g.sd; m_ovf = g.ovf;
        chk({tag, ".acc"},     u_if.abus_out, g.acc);
        chk({tag, ".acc_low"}, u_if.acc_low,  g.acc[8:0]);
        chk({tag, ".z"},       u_if.flag_z,   (g.acc == 0));
        chk({tag, ".n"},       u_if.flag_n,   g.acc[31]);
        chk({tag, ".c"},       u_if.flag_c,   g.c);
        chk({tag, ".sv"},      u_if.st_valid, g.sv);
        chk({tag, ".sd"},      u_if.st_data,  g.sd);
        chk({tag, ".ovf"},     u_if.st_ovf,   g.ovf);
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 0;
        m_acc = 0; m_c = 0; m_sv = 0; m_sd = 0; m_ovf = 0;
        drive(1, 0, 0, 0, 0, 3'd0, 20'h0, 8'h0, 32'h0, 0, 0);
        @(negedge clk);
        tick("reset");
        chk("reset.z_const", u_if.flag_z, 1);
        chk("reset.acc_const", u_if.abus_out, 0);

        // Wrap on INC sets carry and zero.
        drive(0, 0, 0, 1, 0, 3'd0, 20'h0, 8'h0, 32'hFFFF_FFFF, 0, 0); tick("ld_ones");
        drive(0, 0, 0, 0, 0, 3'd1, 20'h0, 8'h0, 32'h0, 0, 0);          tick("inc_wrap");
        chk("inc_wrap.c_const", u_if.flag_c, 1);
        drive(0, 0, 0, 0, 0, 3'd0, 20'h0, 8'h0, 32'h0, 0, 0);          tick("nop_hold_c");
        drive(0, 0, 0, 0, 0, 3'd2, 20'h0, 8'h0, 32'h0, 0, 0);          tick("dec_borrow");
        drive(0, 0, 0, 0, 0, 3'd3, 20'h0, 8'h0, 32'h0, 0, 0);          tick("shl_msb");
        drive(0, 0, 0, 0, 0, 3'd4, 20'h0, 8'h0, 32'h0, 0, 0);          tick("shr_lsb");
        drive(0, 0, 0, 0, 0, 3'd7, 20'h0, 8'h0, 32'h0, 0, 0);          tick("op7_nop");
        drive(0, 0, 0, 0, 0, 3'd5, 20'h0, 8'h0, 32'h0, 0, 0);          tick("clr");

        // Data-memory extension modes.
        drive(0, 0, 1, 0, 1, 3'd0, 20'h0, 8'h80, 32'h0, 0, 0);         tick("dm_sext");
        chk("dm_sext.acc_const", u_if.abus_out, 32'hFFFF_FF80);
        drive(0, 0, 1, 0, 0, 3'd0, 20'h0, 8'h80, 32'h0, 0, 0);         tick("dm_zext");
        chk("dm_zext.low_const", u_if.acc_low, 9'h080);
        drive(0, 1, 0, 0, 1, 3'd0, 20'h8_0001, 8'h0, 32'h0, 0, 0);     tick("cm_sext");

        // Priority: code memory wins over everything else.
        drive(0, 0, 0, 0, 0, 3'd3, 20'h0, 8'h0, 32'h0, 0, 0);          tick("set_c");
        drive(0, 1, 1, 1, 0, 3'd1, 20'h0_0005, 8'h33, 32'h99, 0, 0);   tick("prio");
        chk("prio.acc_const", u_if.abus_out, 32'h5);

        // Store overflow sequence.
        drive(0, 0, 0, 1, 0, 3'd0, 20'h0, 8'h0, 32'h1234_56AB, 0, 0);  tick("ld_st");
        drive(0, 0, 0, 0, 0, 3'd0, 20'h0, 8'h0, 32'h0, 1, 0);          tick("st1");
        drive(0, 0, 0, 0, 0, 3'd1, 20'h0, 8'h0, 32'h0, 1, 0);          tick("st2");
        drive(0, 0, 0, 0, 0, 3'd0, 20'h0, 8'h0, 32'h0, 1, 0);          tick("st3");
        chk("st3.sd_const", u_if.st_data, 8'hAB);
        drive(0, 0, 0, 0, 0, 3'd0, 20'h0, 8'h0, 32'h0, 0, 1);          tick("st_drain");
        drive(0, 0, 0, 0, 0, 3'd0, 20'h0, 8'h0, 32'h0, 0, 1);          tick("rdy_idle");

        // Store with simultaneous load captures the pre-load value.
        drive(0, 0, 0, 1, 0, 3'd0, 20'h0, 8'h0, 32'h55, 0, 0);         tick("ld55");
        drive(0, 0, 0, 1, 0, 3'd0, 20'h0, 8'h0, 32'h77, 1, 0);         tick("st_ld");
        chk("st_ld.sd_const", u_if.st_data, 8'h55);
        drive(0, 0, 0, 0, 0, 3'd1, 20'h0, 8'h0, 32'h0, 1, 1);          tick("refill");
        drive(0, 0, 0, 0, 0, 3'd0, 20'h0, 8'h0, 32'h0, 0, 1);          tick("drain2");

        // Pending store and SHL, then reset drops everything.
        drive(0, 0, 0, 0, 0, 3'd0, 20'h0, 8'h0, 32'h0, 1, 0);          tick("pend");
        drive(0, 0, 0, 0, 0, 3'd3, 20'h0, 8'h0, 32'h0, 0, 0);          tick("pend_shl");
        drive(1, 0, 0, 1, 0, 3'd1, 20'h0, 8'h0, 32'hFF, 1, 1);         tick("rst_ovr");
        chk("rst_ovr.sv_const", u_if.st_valid, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom), 3'($urandom), 20'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
                  ($urandom_range(0, 2) == 0), 1'($urandom));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
